std_div_recon_pipe: RTL
=======================

// Module: std_div_recon_pipe
// PURPOSE
//  Multi-cycle inverse of the unsigned pipelined divider: rebuilds the dividend as
//  out = left*right + addend (quotient, divisor, remainder) using iterative shift-add.
//  Fixed latency and Calyx-style go/done handshake, same as the other *_pipe primitives.
//  Sits beside the divider for multiply-accumulate and for divide round-trip checks.
// PARAMETERS
//  width  32  operand/result width in bits (>=2)
// PORTS
//  clk      in   1      single clock, all state on rising edge
//  reset_n  in   1      asynchronous, active-low reset
//  go       in   1      start/hold request; must stay high until done is seen
//  left     in   width  multiplier (quotient), sampled at start only
//  right    in   width  multiplicand (divisor), sampled at start only
//  addend   in   width  added term (remainder), sampled at start only
//  out      out  width  low width bits of left*right+addend
//  overflow out  1      1 when the full result does not fit in width bits
//  done     out  1      one-cycle completion pulse
// BEHAVIOUR
//  - Reset (reset_n=0, async): state IDLE; out=0, overflow=0, done=0; internal regs 0.
//  - FSM IDLE->BUSY->DONE->IDLE.
//    IDLE: go=1 at edge E0 -> load acc={width'0,addend}, mcand={width'0,right},
//          mplier=left, cnt=width; go to BUSY.
//    BUSY: each edge: if mplier[0] acc+=mcand; mcand<<=1; mplier>>=1; cnt-=1.
//          Exactly width iterations (E1..Ewidth), no early exit: latency is data-independent.
//          Edge E(width+1): out<=acc[width-1:0], overflow<=|acc[2*width-1:width],
//          done<=1; go to DONE.
//    DONE: done=0 from the next edge on (exactly one-cycle pulse); hold until go=0, then IDLE.
//  - done is visible in the cycle after E(width+1), i.e. width+2 edges after start.
//  - acc is 2*width bits: max result (2^w-1)^2+(2^w-1) < 2^(2w), so no carry is lost.
//  - out/overflow hold their last result until the next completion or reset.
//    Deasserting go does not clear them.
//  - go held high in DONE: no restart and no second done; a new op needs go low for >=1 edge.
//  - go dropped during BUSY: abort to IDLE at that edge; no done; out/overflow unchanged.
//  - Input changes after E0 are ignored.
//  - Reset asserted mid-BUSY clears all state without waiting for a clock edge.
//  - Under VERILATOR, on completion compare against (left*right+addend) sampled at start;
//    $error on mismatch in either the truncated value or overflow.
// STRUCTURE
//  - Shared package std_arith_pkg: typedef enum logic [1:0] {IDLE,BUSY,DONE} pipe_state_t.
//    The divider's future FSM reuses the same type.
//  - Single module, no sub-module.
//    The datapath (acc/mcand/mplier/cnt, $clog2(width+1)-bit counter) is too small to split.
// TESTING (width=8 unless noted)
//  1. left=13,right=7,addend=3, go held -> out=94, overflow=0.
//     done high exactly one cycle, 10 edges after start; no second done while go stays high.
//  2. Round trip: divide 200/9 -> q=22,r=2; feed left=22,right=9,addend=2 -> out=200, overflow=0.
//  3. left=255,right=255,addend=255 -> full 0xFF00 -> out=0x00, overflow=1; same latency.
//  4. left=0,right=0xAB,addend=5 -> out=5 after the same 10 edges (no early exit).
//  5. Completed op (out=94); new op, go dropped 4 edges in -> no done, out stays 94.
//     go low 1 edge, then left=2,right=3,addend=1 -> out=7.
//  6. reset_n low between edges mid-BUSY -> out=0,done=0,overflow=0 immediately.
//     After release, test 1 repeats correctly. Also run width=32: 0xFFFFFFFF*2+1 -> out=0xFFFFFFFF, overflow=1.

Source files
------------

// File: rtl/std_arith_pkg.sv
// Shared arithmetic-primitive package.
// Holds the handshake FSM state type used by the *_pipe primitives
// (the recombining multiplier now, the divider's FSM later).
package std_arith_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } pipe_state_t;

endpackage

// File: rtl/std_div_recon_pipe.sv
// std_div_recon_pipe: multi-cycle inverse of the unsigned pipelined divider.
// Rebuilds out = left*right + addend by iterative shift-add, with a fixed,
// data-independent latency and a go/done handshake.
//
// Ports
//   clk       single clock, rising edge
//   reset_n   asynchronous active-low reset
//   go        start/hold request, held high until done is seen
//   left      multiplier (quotient), sampled at start
//   right     multiplicand (divisor), sampled at start
//   addend    added term (remainder), sampled at start
//   out       low width bits of left*right+addend (held until next completion)
//   overflow  1 when the full result needs more than width bits
//   done      one-cycle completion pulse
module std_div_recon_pipe
  import std_arith_pkg::*;
#(
  parameter int width = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             go,
  input  logic [width-1:0] left,
  input  logic [width-1:0] right,
  input  logic [width-1:0] addend,
  output logic [width-1:0] out,
  output logic             overflow,
  output logic             done
);

  localparam int CNT_W = $clog2(width + 1);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(width);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

  pipe_state_t r_state;
  pipe_state_t w_state_nxt;

  // acc is 2*width bits wide: the largest result (2^w-1)^2 + (2^w-1) still fits.
  logic [2*width-1:0] r_acc;
  logic [2*width-1:0] r_mcand;
  logic [width-1:0]   r_mplier;
  logic [CNT_W-1:0]   r_cnt;
  logic [width-1:0]   r_out;
  logic               r_overflow;
  logic               r_done;

  logic w_start;
  logic w_step;
  logic w_fin;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and datapath strobes; dropping go in BUSY aborts the op.
  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_step      = 1'b0;
    w_fin       = 1'b0;
    case (r_state)
      IDLE: begin
        if (go) begin
          w_start     = 1'b1;
          w_state_nxt = BUSY;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      BUSY: begin
        if (!go) begin
          w_state_nxt = IDLE;
        end else if (r_cnt != CNT_ZERO) begin
          w_step      = 1'b1;
          w_state_nxt = BUSY;
        end else begin
          w_fin       = 1'b1;
          w_state_nxt = DONE;
        end
      end
      DONE: begin
        // A new operation needs go low for at least one edge.
        if (!go) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = DONE;
        end
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Shift-add datapath: always exactly width iterations, no early exit.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_acc    <= {(2*width){1'b0}};
      r_mcand  <= {(2*width){1'b0}};
      r_mplier <= {width{1'b0}};
      r_cnt    <= CNT_ZERO;
    end else if (w_start) begin
      r_acc    <= {{width{1'b0}}, addend};
      r_mcand  <= {{width{1'b0}}, right};
      r_mplier <= left;
      r_cnt    <= CNT_INIT;
    end else if (w_step) begin
      if (r_mplier[0]) begin
        r_acc <= r_acc + r_mcand;
      end else begin
        r_acc <= r_acc;
      end
      r_mcand  <= {r_mcand[2*width-2:0], 1'b0};
      r_mplier <= {1'b0, r_mplier[width-1:1]};
      r_cnt    <= r_cnt - CNT_ONE;
    end else begin
      r_acc    <= r_acc;
      r_mcand  <= r_mcand;
      r_mplier <= r_mplier;
      r_cnt    <= r_cnt;
    end
  end

  // Result registers: out/overflow only change on completion; done is a pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out      <= {width{1'b0}};
      r_overflow <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_done <= w_fin;
      if (w_fin) begin
        r_out      <= r_acc[width-1:0];
        r_overflow <= |r_acc[2*width-1:width];
      end else begin
        r_out      <= r_out;
        r_overflow <= r_overflow;
      end
    end
  end

  assign out      = r_out;
  assign overflow = r_overflow;
  assign done     = r_done;

  logic [2*width-1:0] r_chk_exp;

  // Reference result captured from the operands at start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_chk_exp <= {(2*width){1'b0}};
    end else if (w_start) begin
      r_chk_exp <= {{width{1'b0}}, left} * {{width{1'b0}}, right} + {{width{1'b0}}, addend};
    end else begin
      r_chk_exp <= r_chk_exp;
    end
  end

  // Published result must match the reference while done is high.
  always_ff @(posedge clk) begin
    if (reset_n && r_done &&
        ((r_out != r_chk_exp[width-1:0]) ||
         (r_overflow != (|r_chk_exp[2*width-1:width])))) begin
      $error("std_div_recon_pipe: result %0h/%0b differs from reference %0h",
             r_out, r_overflow, r_chk_exp);
    end
  end

endmodule
